// File: rtl/divisor_5b.sv
// divisor_5b: sequential 5-bit unsigned restoring divider, one quotient bit per clock,
// built around the restador subtraction stage.
module restador (
    input  logic [4:0] minuendo,
    input  logic [4:0] sustraendo,
    output logic [4:0] diferencia,
    output logic       cout
);
    assign {cout, diferencia} = {1'b1, minuendo} - {1'b0, sustraendo};
endmodule

module divisor_5b (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] dividendo,
    input  logic [4:0] divisor,
    output logic [4:0] cociente,
    output logic [4:0] residuo,
    output logic       busy,
    output logic       done,
    output logic       div_cero
);
    typedef enum logic [1:0] {REPOSO, CALCULO, FIN} estado_t;
    estado_t estado, sig;
    logic [4:0] r, q, d, s, t, nr, nq;
    logic [2:0] cnt;
    logic       c, acepta;
    assign s = {r[3:0], q[4]};
    restador u_res (.minuendo(s), .sustraendo(d), .diferencia(t), .cout(c));
    // r[4] set means the shifted remainder overflowed 5 bits, so it certainly exceeds d
    assign acepta = r[4] | c;
    assign nr = acepta ? t : s;
    assign nq = {q[3:0], acepta};
    assign busy = estado == CALCULO;
    assign done = estado == FIN;
    always_comb begin
        sig = REPOSO;
        sig = estado == REPOSO  ? (start ? (divisor == 5'd0 ? FIN : CALCULO) : REPOSO) :
              estado == CALCULO ? (cnt == 3'd4 ? FIN : CALCULO) : REPOSO;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) estado <= REPOSO;
        else estado <= sig;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            q <= '0;
            d <= '0;
            cnt <= '0;
            cociente <= '0;
            residuo <= '0;
            div_cero <= 1'b0;
        end else if (estado == REPOSO && start) begin
            if (divisor != 5'd0) begin
                r <= '0;
                q <= dividendo;
                d <= divisor;
                cnt <= '0;
                div_cero <= 1'b0;
            end else begin
                cociente <= 5'd31;
                residuo <= dividendo;
                div_cero <= 1'b1;
            end
        end else if (estado == CALCULO) begin
            r <= nr;
            q <= nq;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd4) begin
                cociente <= nq;
                residuo <= nr;
            end
        end
    end
endmodule

// File: tb/tb_divisor_5b.sv
// tb_divisor_5b: directed and exhaustive checks of divisor_5b against an arithmetic reference model.
module tb_divisor_5b;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] dividendo = '0;
    logic [4:0] divisor = '0;
    logic [4:0] cociente, residuo;
    logic       busy, done, div_cero;
    logic       go = 1'b0;
    int         total = 0;
    int         passed = 0;

    divisor_5b dut (
        .clk(clk), .rst(rst), .start(start), .dividendo(dividendo), .divisor(divisor),
        .cociente(cociente), .residuo(residuo), .busy(busy), .done(done), .div_cero(div_cero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Model: phase 0 idle, 1..5 computing, 6 done cycle; results from plain / and %
    logic [2:0] ph = '0;
    logic [4:0] mq = '0, mr = '0, pq = '0, pr = '0, ca = '0, cb = '0;
    logic       mdz = 1'b0;
    always @(posedge clk or posedge rst)
        if (rst) begin
            ph <= '0; mq <= '0; mr <= '0; mdz <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ca <= dividendo;
                cb <= divisor;
                if (divisor == 0) begin
                    ph <= 3'd6; mq <= 5'd31; mr <= dividendo; mdz <= 1'b1;
                end else begin
                    ph <= 3'd1; pq <= dividendo / divisor; pr <= dividendo % divisor; mdz <= 1'b0;
                end
            end
        end else if (ph == 5) begin
            ph <= 3'd6; mq <= pq; mr <= pr;
        end else if (ph == 6) ph <= '0;
        else ph <= ph + 3'd1;

    always @(negedge clk)
        if (go) begin
            chk("busy", busy, (ph >= 1 && ph <= 5));
            chk("done", done, ph == 6);
            chk("div_cero", div_cero, mdz);
            chk("cociente", cociente, mq);
            chk("residuo", residuo, mr);
            if (ph == 6 && !mdz) begin
                chk("invariant", cociente * cb + residuo, ca);
                chk("res_lt_div", residuo < cb, 1);
            end
        end

    task automatic op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] eq,
                      input logic [4:0] er, input logic edz);
        int n = 0;
        @(posedge clk); #1;
        start = 1'b1; dividendo = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividendo = 5'($urandom); divisor = 5'($urandom);
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("lit_q", cociente, eq);
        chk("lit_r", residuo, er);
        chk("lit_dz", div_cero, edz);
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_q", cociente, 0);
        chk("rst_r", residuo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_cero, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        go = 1'b1;
        op(23, 5, 4, 3, 0);
        op(31, 1, 31, 0, 0);
        op(7, 9, 0, 7, 0);
        op(30, 17, 1, 13, 0);
        op(31, 31, 1, 0, 0);
        op(31, 16, 1, 15, 0);
        op(12, 0, 31, 12, 1);
        op(12, 4, 3, 0, 0);
        op(23, 5, 4, 3, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            dividendo = 5'($urandom); divisor = 5'($urandom);
        end
        chk("hold_q", cociente, 4);
        chk("hold_r", residuo, 3);
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            dividendo = 5'($urandom); divisor = 5'($urandom_range(0, 31));
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        start = 1'b1; dividendo = 5'd23; divisor = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_q", cociente, 0);
        chk("midrst_r", residuo, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("idle_after_rst", busy | done, 0);
        op(9, 2, 4, 1, 0);
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                op(5'(a), 5'(b), b == 0 ? 5'd31 : 5'(a / b), b == 0 ? 5'(a) : 5'(a % b), b == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
